// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: forwarding select codes,
// control FSM state encoding and the scoreboard entry layout.
package hazard_ctrl_pkg;

   // Operand source selects presented to the execute-stage bypass muxes.
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   // Control FSM state encoding.
   typedef logic [1:0] ctrl_state_t;
   localparam ctrl_state_t ST_RUN   = 2'd0;
   localparam ctrl_state_t ST_STALL = 2'd1;
   localparam ctrl_state_t ST_FLUSH = 2'd2;

   // One in-flight instruction as seen by the hazard logic.
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wen;
      logic       is_load;
   } sb_entry_t;

   // True when an in-flight producer feeds a source the decode stage reads.
   // x0 is hardwired to zero, so a write to it never creates a dependency.
   function automatic logic src_hit(input logic       valid,
                                    input logic       wen,
                                    input logic [4:0] rd,
                                    input logic [4:0] src,
                                    input logic       used);
      return used && valid && wen && (rd != 5'd0) && (rd == src);
   endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot. Reset and bubble both leave an empty slot; otherwise
// the slot captures its upstream neighbour whenever load is asserted.
module hazard_sb_entry
   import hazard_ctrl_pkg::*;
(
   input  logic      clock,
   input  logic      reset,
   input  logic      load,
   input  logic      bubble,
   input  sb_entry_t d,
   output sb_entry_t q
);

   // Slot register: reset beats bubble, bubble beats load.
   always_ff @(posedge clock) begin
      if (reset || bubble) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks the instructions in EX, MEM and WB,
// raises STALL on unresolved read-after-write dependencies, raises DUMP for
// FLUSH_CYCLES cycles after a redirect, and counts stall cycles.
// Build option: define HAZARD_CTRL_FWD_EN to enable operand forwarding; in the
// default build the forward selects stay at regfile and every dependency
// stalls until its producer retires.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_BITS     = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                dec_valid,
   input  logic [4:0]          dec_rs1,
   input  logic [4:0]          dec_rs2,
   input  logic                dec_use_rs1,
   input  logic                dec_use_rs2,
   input  logic [4:0]          dec_rd,
   input  logic                dec_wEn,
   input  logic                dec_is_load,
   input  logic                ex_redirect,
   output logic                STALL,
   output logic                DUMP,
   output logic [1:0]          fwd_a_sel,
   output logic [1:0]          fwd_b_sel,
   output logic [CNT_BITS-1:0] stall_cycles,
   output ctrl_state_t         fsm_state
);

   localparam logic [2:0]          FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [CNT_BITS-1:0] CNT_ONE    = {{(CNT_BITS-1){1'b0}}, 1'b1};

   sb_entry_t           dec_e;
   sb_entry_t           ex_e;
   sb_entry_t           mem_e;
   sb_entry_t           wb_e;
   logic                ex_bubble;
   logic                use_a;
   logic                use_b;
   logic                a_ex;
   logic                a_mem;
   logic                a_wb;
   logic                b_ex;
   logic                b_mem;
   logic                b_wb;
   logic                stall_cond;
   logic [2:0]          flush_cnt;
   logic [2:0]          flush_cnt_nxt;
   ctrl_state_t         state;
   ctrl_state_t         state_nxt;
   logic [CNT_BITS-1:0] stall_cnt;
   logic                unused_bits;

   // The WB slot only ever matters as a producer; its load flag is not needed.
   assign unused_bits = wb_e.is_load;

   assign dec_e = '{valid: dec_valid, rd: dec_rd, wen: dec_wEn, is_load: dec_is_load};

   // A held (stalled) or squashed decode instruction must not enter EX.
   assign ex_bubble = ~(dec_valid & ~STALL & ~DUMP);

   hazard_sb_entry u_ex (
      .clock  (clock),
      .reset  (reset),
      .load   (1'b1),
      .bubble (ex_bubble),
      .d      (dec_e),
      .q      (ex_e)
   );

   hazard_sb_entry u_mem (
      .clock  (clock),
      .reset  (reset),
      .load   (1'b1),
      .bubble (1'b0),
      .d      (ex_e),
      .q      (mem_e)
   );

   hazard_sb_entry u_wb (
      .clock  (clock),
      .reset  (reset),
      .load   (1'b1),
      .bubble (1'b0),
      .d      (mem_e),
      .q      (wb_e)
   );

   assign use_a = dec_valid & dec_use_rs1;
   assign use_b = dec_valid & dec_use_rs2;

   assign a_ex  = src_hit(ex_e.valid,  ex_e.wen,  ex_e.rd,  dec_rs1, use_a);
   assign a_mem = src_hit(mem_e.valid, mem_e.wen, mem_e.rd, dec_rs1, use_a);
   assign a_wb  = src_hit(wb_e.valid,  wb_e.wen,  wb_e.rd,  dec_rs1, use_a);
   assign b_ex  = src_hit(ex_e.valid,  ex_e.wen,  ex_e.rd,  dec_rs2, use_b);
   assign b_mem = src_hit(mem_e.valid, mem_e.wen, mem_e.rd, dec_rs2, use_b);
   assign b_wb  = src_hit(wb_e.valid,  wb_e.wen,  wb_e.rd,  dec_rs2, use_b);

`ifdef HAZARD_CTRL_FWD_EN
   // Only a load still in EX has no data to bypass yet; every other producer
   // forwards, the youngest one winning when a register is written twice.
   always_comb begin
      stall_cond = (a_ex | b_ex) & ex_e.is_load;

      if (a_ex) begin
         fwd_a_sel = FWD_EX;
      end else if (a_mem) begin
         fwd_a_sel = FWD_MEM;
      end else if (a_wb) begin
         fwd_a_sel = FWD_WB;
      end else begin
         fwd_a_sel = FWD_RF;
      end

      if (b_ex) begin
         fwd_b_sel = FWD_EX;
      end else if (b_mem) begin
         fwd_b_sel = FWD_MEM;
      end else if (b_wb) begin
         fwd_b_sel = FWD_WB;
      end else begin
         fwd_b_sel = FWD_RF;
      end
   end
`else
   // No bypass network: wait for any in-flight producer to retire.
   always_comb begin
      stall_cond = a_ex | a_mem | a_wb | b_ex | b_mem | b_wb;
      fwd_a_sel  = FWD_RF;
      fwd_b_sel  = FWD_RF;
   end
`endif

   // A redirect squashes the younger stages, so it overrides any stall.
   assign DUMP  = ex_redirect | (flush_cnt != 3'd0);
   assign STALL = stall_cond & ~DUMP;

   // Flush counter: reloaded on every redirect, otherwise counts down to 0.
   always_comb begin
      flush_cnt_nxt = flush_cnt;
      if (ex_redirect) begin
         flush_cnt_nxt = FLUSH_LOAD;
      end else if (flush_cnt != 3'd0) begin
         flush_cnt_nxt = flush_cnt - 3'd1;
      end
   end

   // Control FSM next state.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN: begin
            if (ex_redirect) begin
               state_nxt = ST_FLUSH;
            end else if (stall_cond) begin
               state_nxt = ST_STALL;
            end
         end
         ST_STALL: begin
            if (ex_redirect) begin
               state_nxt = ST_FLUSH;
            end else if (!stall_cond) begin
               state_nxt = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (!ex_redirect && (flush_cnt_nxt == 3'd0)) begin
               state_nxt = ST_RUN;
            end
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   // Registered control state and the saturating stall counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_RUN;
         flush_cnt <= 3'd0;
         stall_cnt <= '0;
      end else begin
         state     <= state_nxt;
         flush_cnt <= flush_cnt_nxt;
         if (STALL && (stall_cnt != {CNT_BITS{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
      end
   end

   assign stall_cycles = stall_cnt;
   assign fsm_state    = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl. Expected {STALL, DUMP, fwd_a_sel, fwd_b_sel} values
// are queued as each decode cycle is driven and popped when sampled on the
// falling edge. Expectations follow HAZARD_CTRL_FWD_EN when it is defined.
module tb_hazard_ctrl;

   localparam int CNT_BITS = 4;
`ifdef HAZARD_CTRL_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   // Expected output word: {STALL, DUMP, fwd_a_sel, fwd_b_sel}
   localparam logic [5:0] E_NONE  = 6'b000000;
   localparam logic [5:0] E_STALL = 6'b100000;
   localparam logic [5:0] E_DUMP  = 6'b010000;

   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_STALL = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   logic                clock;
   logic                reset;
   logic                dec_valid;
   logic [4:0]          dec_rs1;
   logic [4:0]          dec_rs2;
   logic                dec_use_rs1;
   logic                dec_use_rs2;
   logic [4:0]          dec_rd;
   logic                dec_wEn;
   logic                dec_is_load;
   logic                ex_redirect;
   logic                STALL;
   logic                DUMP;
   logic [1:0]          fwd_a_sel;
   logic [1:0]          fwd_b_sel;
   logic [CNT_BITS-1:0] stall_cycles;
   logic [1:0]          fsm_state;

   logic [5:0] exp_q[$];
   int         n_tests;
   int         n_fail;

   hazard_ctrl #(
      .FLUSH_CYCLES (2),
      .CNT_BITS     (CNT_BITS)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .dec_valid    (dec_valid),
      .dec_rs1      (dec_rs1),
      .dec_rs2      (dec_rs2),
      .dec_use_rs1  (dec_use_rs1),
      .dec_use_rs2  (dec_use_rs2),
      .dec_rd       (dec_rd),
      .dec_wEn      (dec_wEn),
      .dec_is_load  (dec_is_load),
      .ex_redirect  (ex_redirect),
      .STALL        (STALL),
      .DUMP         (DUMP),
      .fwd_a_sel    (fwd_a_sel),
      .fwd_b_sel    (fwd_b_sel),
      .stall_cycles (stall_cycles),
      .fsm_state    (fsm_state)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want run to complete");
      $fatal(1, "watchdog expired");
   end

   task automatic do_reset();
      reset       = 1'b1;
      ex_redirect = 1'b0;
      dec_valid   = 1'b0;
      dec_use_rs1 = 1'b0;
      dec_use_rs2 = 1'b0;
      dec_wEn     = 1'b0;
      dec_is_load = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic wen, input logic ld, input logic [5:0] e);
      dec_valid   = v;
      dec_rs1     = rs1;
      dec_use_rs1 = u1;
      dec_rs2     = rs2;
      dec_use_rs2 = u2;
      dec_rd      = rd;
      dec_wEn     = wen;
      dec_is_load = ld;
      exp_q.push_back(e);
   endtask

   task automatic drive_w(input logic [4:0] rd, input logic ld, input logic [5:0] e);
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, ld, e);
   endtask

   task automatic drive_r(input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [5:0] e);
      drive(1'b1, rs1, u1, rs2, u2, 5'd0, 1'b0, 1'b0, e);
   endtask

   task automatic drive_idle(input logic [5:0] e);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, e);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [5:0] got;
      logic [5:0] want;
      ex_redirect = 1'b0;
      reset       = 1'b1;
      drive_idle(E_NONE);
      @(posedge clock);
      #1;
      @(negedge clock);
      got  = {STALL, DUMP, fwd_a_sel, fwd_b_sel};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want %b", got, want);
      end
      n_tests++;
      if (stall_cycles !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_counter: got %0d want 0", stall_cycles);
      end
      n_tests++;
      if (fsm_state !== S_RUN) begin
         n_fail++;
         $display("FAIL reset_state: got %0d want %0d", fsm_state, S_RUN);
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // ALU op writes x3, next instruction reads x3 on rs2.
   task automatic test_raw_hazard();
      logic [5:0]          got;
      logic [5:0]          want;
      logic [CNT_BITS-1:0] want_cnt;
      do_reset();
      for (int i = 0; i < (FWD ? 3 : 5); i++) begin
         if (i == 0) drive_w(5'd3, 1'b0, E_NONE);
         else if (FWD && i == 1) drive(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0, 6'b000001);
         else if (FWD) drive_idle(E_NONE);
         else drive(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0, (i < 4) ? E_STALL : E_NONE);
         @(negedge clock);
         got  = {STALL, DUMP, fwd_a_sel, fwd_b_sel};
         want = exp_q.pop_front();
         n_tests++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL raw_hazard step %0d: got %b want %b", i, got, want);
         end
`ifndef HAZARD_CTRL_FWD_EN
         if (i == 2) begin
            n_tests++;
            if (fsm_state !== S_STALL) begin
               n_fail++;
               $display("FAIL raw_hazard_state: got %0d want %0d", fsm_state, S_STALL);
            end
         end
`endif
         @(posedge clock);
         #1;
      end
      want_cnt = FWD ? 4'd0 : 4'd3;
      n_tests++;
      if (stall_cycles !== want_cnt) begin
         n_fail++;
         $display("FAIL raw_hazard_count: got %0d want %0d", stall_cycles, want_cnt);
      end
   endtask

   // Load to x5 in EX, decode reads rs1 = x5.
   task automatic test_load_use();
      logic [5:0]          got;
      logic [5:0]          want;
      logic [CNT_BITS-1:0] want_cnt;
      int                  stall_len;
      stall_len = FWD ? 1 : 3;
      do_reset();
      for (int i = 0; i < stall_len + 2; i++) begin
         if (i == 0) drive_w(5'd5, 1'b1, E_NONE);
         else drive_r(5'd5, 1'b1, 5'd0, 1'b0,
                      (i <= stall_len) ? (FWD ? 6'b100100 : E_STALL)
                                       : (FWD ? 6'b001000 : E_NONE));
         @(negedge clock);
         got  = {STALL, DUMP, fwd_a_sel, fwd_b_sel};
         want = exp_q.pop_front();
         n_tests++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL load_use step %0d: got %b want %b", i, got, want);
         end
         @(posedge clock);
         #1;
      end
      want_cnt = FWD ? 4'd1 : 4'd3;
      n_tests++;
      if (stall_cycles !== want_cnt) begin
         n_fail++;
         $display("FAIL load_use_count: got %0d want %0d", stall_cycles, want_cnt);
      end
   endtask

   // Two back-to-back writers of x4 followed by readers of x4.
   task automatic test_youngest();
      logic [5:0] got;
      logic [5:0] want;
      do_reset();
      for (int i = 0; i < 6; i++) begin
`ifdef HAZARD_CTRL_FWD_EN
         case (i)
            0, 1:    drive_w(5'd4, 1'b0, E_NONE);
            2:       drive_r(5'd4, 1'b1, 5'd4, 1'b1, 6'b000101);
            3:       drive_r(5'd4, 1'b1, 5'd0, 1'b0, 6'b001000);
            4:       drive_r(5'd0, 1'b0, 5'd4, 1'b1, 6'b000011);
            default: drive_r(5'd4, 1'b1, 5'd0, 1'b0, E_NONE);
         endcase
`else
         if (i < 2) drive_w(5'd4, 1'b0, E_NONE);
         else drive_r(5'd4, 1'b1, 5'd4, 1'b1, (i < 5) ? E_STALL : E_NONE);
`endif
         @(negedge clock);
         got  = {STALL, DUMP, fwd_a_sel, fwd_b_sel};
         want = exp_q.pop_front();
         n_tests++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL youngest step %0d: got %b want %b", i, got, want);
         end
         @(posedge clock);
         #1;
      end
   endtask

   // Redirect pulse, then a redirect repeated during the flush window.
   task automatic test_redirect();
      logic [5:0] got;
      logic [5:0] want;
      logic [1:0] want_st;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         ex_redirect = (i == 0 || i == 4 || i == 5);
         case (i)
            0, 1:    drive_w(5'd7, 1'b0, E_DUMP);
            2, 3:    drive_r(5'd7, 1'b1, 5'd0, 1'b0, E_NONE);
            4, 5, 6: drive_idle(E_DUMP);
            default: drive_idle(E_NONE);
         endcase
         @(negedge clock);
         got  = {STALL, DUMP, fwd_a_sel, fwd_b_sel};
         want = exp_q.pop_front();
         n_tests++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL redirect step %0d: got %b want %b", i, got, want);
         end
         if (i == 1 || i == 2) begin
            want_st = (i == 1) ? S_FLUSH : S_RUN;
            n_tests++;
            if (fsm_state !== want_st) begin
               n_fail++;
               $display("FAIL redirect_state step %0d: got %0d want %0d", i, fsm_state, want_st);
            end
         end
         @(posedge clock);
         #1;
      end
      ex_redirect = 1'b0;
   endtask

   // Redirect arrives in the same cycle as a load-use dependency.
   task automatic test_redirect_beats_stall();
      logic [5:0] got;
      logic [5:0] want;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         ex_redirect = (i == 1);
         case (i)
            0:       drive_w(5'd5, 1'b1, E_NONE);
            1:       drive_r(5'd5, 1'b1, 5'd0, 1'b0, FWD ? 6'b010100 : E_DUMP);
            2:       drive_r(5'd5, 1'b1, 5'd0, 1'b0, FWD ? 6'b011000 : E_DUMP);
            default: drive_idle(E_NONE);
         endcase
         @(negedge clock);
         got  = {STALL, DUMP, fwd_a_sel, fwd_b_sel};
         want = exp_q.pop_front();
         n_tests++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL redirect_beats_stall step %0d: got %b want %b", i, got, want);
         end
         @(posedge clock);
         #1;
      end
      n_tests++;
      if (stall_cycles !== 4'd0) begin
         n_fail++;
         $display("FAIL redirect_beats_stall_count: got %0d want 0", stall_cycles);
      end
   endtask

   // x0 traffic never stalls; reset abandons a flush and a stall.
   task automatic test_x0_and_reset();
      logic [5:0] got;
      logic [5:0] want;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         ex_redirect = (i == 3);
         reset       = (i == 4 || i == 8);
         case (i)
            0:       drive_w(5'd0, 1'b0, E_NONE);
            1, 2:    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, E_NONE);
            3, 4:    drive_idle(E_DUMP);
            5:       drive_idle(E_NONE);
            6:       drive_w(5'd3, 1'b0, E_NONE);
            7:       drive_r(5'd3, 1'b1, 5'd0, 1'b0, FWD ? 6'b000100 : E_STALL);
            8:       drive_r(5'd3, 1'b1, 5'd0, 1'b0, FWD ? 6'b001000 : E_STALL);
            default: drive_r(5'd3, 1'b1, 5'd0, 1'b0, E_NONE);
         endcase
         @(negedge clock);
         got  = {STALL, DUMP, fwd_a_sel, fwd_b_sel};
         want = exp_q.pop_front();
         n_tests++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL x0_reset step %0d: got %b want %b", i, got, want);
         end
         if (i == 5 || i == 9) begin
            n_tests++;
            if (fsm_state !== S_RUN) begin
               n_fail++;
               $display("FAIL x0_reset_state step %0d: got %0d want %0d", i, fsm_state, S_RUN);
            end
         end
         if (i == 9) begin
            n_tests++;
            if (stall_cycles !== 4'd0) begin
               n_fail++;
               $display("FAIL x0_reset_count: got %0d want 0", stall_cycles);
            end
         end
         @(posedge clock);
         #1;
      end
      reset       = 1'b0;
      ex_redirect = 1'b0;
   endtask

   // Random independent traffic: writers use x0..x15, readers x16..x31.
   task automatic test_back_to_back();
      logic [5:0] got;
      logic [5:0] want;
      do_reset();
      for (int i = 0; i < 24; i++) begin
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(16, 31)), 1'($urandom_range(0, 1)),
               5'($urandom_range(16, 31)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), E_NONE);
         @(negedge clock);
         got  = {STALL, DUMP, fwd_a_sel, fwd_b_sel};
         want = exp_q.pop_front();
         n_tests++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL back_to_back step %0d: got %b want %b", i, got, want);
         end
         @(posedge clock);
         #1;
      end
      n_tests++;
      if (stall_cycles !== 4'd0) begin
         n_fail++;
         $display("FAIL back_to_back_count: got %0d want 0", stall_cycles);
      end
   endtask

   // Repeated load-use pairs drive the 4-bit counter into saturation.
   task automatic test_saturation();
      logic [5:0]          got;
      logic [5:0]          want;
      logic [CNT_BITS-1:0] want_cnt;
      int                  stall_len;
      stall_len = FWD ? 1 : 3;
      do_reset();
      for (int j = 0; j < 20; j++) begin
         for (int k = 0; k <= stall_len + 1; k++) begin
            if (k == 0) drive_w(5'd3, 1'b1, E_NONE);
            else drive_r(5'd3, 1'b1, 5'd0, 1'b0,
                         (k <= stall_len) ? (FWD ? 6'b100100 : E_STALL)
                                          : (FWD ? 6'b001000 : E_NONE));
            @(negedge clock);
            got  = {STALL, DUMP, fwd_a_sel, fwd_b_sel};
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
               n_fail++;
               $display("FAIL saturation pair %0d step %0d: got %b want %b", j, k, got, want);
            end
            @(posedge clock);
            #1;
         end
         if (j == 3) begin
            want_cnt = FWD ? 4'd4 : 4'd12;
            n_tests++;
            if (stall_cycles !== want_cnt) begin
               n_fail++;
               $display("FAIL saturation_mid_count: got %0d want %0d", stall_cycles, want_cnt);
            end
         end
      end
      n_tests++;
      if (stall_cycles !== 4'd15) begin
         n_fail++;
         $display("FAIL saturation_count: got %0d want 15", stall_cycles);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_tests     = 0;
      n_fail      = 0;
      reset       = 1'b1;
      ex_redirect = 1'b0;
      dec_valid   = 1'b0;
      dec_rs1     = 5'd0;
      dec_rs2     = 5'd0;
      dec_use_rs1 = 1'b0;
      dec_use_rs2 = 1'b0;
      dec_rd      = 5'd0;
      dec_wEn     = 1'b0;
      dec_is_load = 1'b0;

      test_reset();
      test_raw_hazard();
      test_load_use();
      test_youngest();
      test_redirect();
      test_redirect_beats_stall();
      test_x0_and_reset();
      test_back_to_back();
      test_saturation();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
